// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter: DATA store pushes a byte into a TX FIFO, FSM drains it onto txd.
// Latency: a write into an empty FIFO with the line idle pops one edge later; txd falls right after that pop.
// Backpressure: none toward the core; a store that finds the FIFO full is dropped and sets sticky ovf. Parity: UART_TX_PARITY_EN.
module uart_tx_port #(
    parameter logic [31:0] BASE   = 32'h804,
    parameter int          CLKDIV = 16,
    parameter int          DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset1,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKDIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   baud;
    logic [2:0]      bitcnt;
    logic [7:0]      shift;
    logic            baud_end;
    logic            pop;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic            full, empty;
    logic            data_hit, stat_hit, wr_data, push, drop, ovf;
    logic [23:0]     unused_wdata;

    assign unused_wdata = wdata[31:8];

    // Register decode and read mux
    assign data_hit = (addr == BASE);
    assign stat_hit = (addr == BASE + 32'd4);
    assign sel      = data_hit | stat_hit;
    assign rdata    = stat_hit ? {29'd0, ovf, full, empty} : 32'd0;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign wr_data  = we & data_hit;
    // A pop on the same edge frees a slot, so a store to a full FIFO still lands.
    assign push     = wr_data & (~full | pop);
    assign drop     = wr_data & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset1) begin
        if (!reset1) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (re && stat_hit) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par;
`endif

    assign baud_end = (baud == BW'(CLKDIV - 1));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_end && bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // Back-to-back frames: pop straight into the next start bit.
                if (baud_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset1) begin
        if (!reset1) begin
            state  <= IDLE;
            baud   <= '0;
            bitcnt <= 3'd0;
            shift  <= 8'd0;
`ifdef UART_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state_nxt != state || baud_end || state == IDLE) begin
                baud <= '0;
            end else begin
                baud <= baud + BW'(1);
            end
            if (pop) begin
                shift  <= mem[rptr];
                bitcnt <= 3'd0;
`ifdef UART_TX_PARITY_EN
                par    <= ^mem[rptr];
`endif
            end else if (state == DATA && baud_end) begin
                shift  <= {1'b0, shift[7:1]};
                bitcnt <= bitcnt + 3'd1;
            end
        end
    end

    always_comb begin
        txd = 1'b1;
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd = par;
`endif
            default: txd = 1'b1;
        endcase
    end

    assign busy = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboarded bench for uart_tx_port: stimulus queues expected frames, a line monitor decodes txd and compares.
`timescale 1ns/1ps
module tb_uart_tx_port;
    localparam int          CLKDIV = 4;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'h804;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CLKDIV;

    logic        clk = 1'b0;
    logic        reset1 = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic        sel;
    logic [31:0] rdata;
    logic        txd;
    logic        busy;

    typedef struct packed {
        logic [7:0] b;
        logic       contig;
    } exp_t;

    exp_t   sbq[$];
    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    longint last_end = -100;

    uart_tx_port #(.BASE(BASE), .CLKDIV(CLKDIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset1(reset1), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .sel(sel), .rdata(rdata), .txd(txd), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b, input bit accepted, input bit contig);
        exp_t e;
        e.b      = b;
        e.contig = contig;
        addr  = BASE;
        wdata = {24'hC3A5F0, b};
        we    = 1'b1;
        if (accepted) sbq.push_back(e);
        @(negedge clk);
        we   = 1'b0;
        addr = 32'd0;
    endtask

    task automatic rd_status(input string name, input logic [31:0] exp);
        addr = BASE + 32'd4;
        re   = 1'b1;
        #1 chk(name, rdata, exp);
        @(negedge clk);
        re   = 1'b0;
        addr = 32'd0;
    endtask

    task automatic wait_idle(input string name, input int lim);
        int n;
        n = 0;
        while ((busy || sbq.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (busy || sbq.size() != 0) begin
            errors++;
            $display("FAIL %s: timeout busy=%0b pending=%0d required idle", name, busy, sbq.size());
        end
    endtask

    // Line monitor: decodes each frame and checks it against the head of the scoreboard.
    task automatic mon_frame();
        exp_t        e;
        logic [10:0] pat;
        logic [10:0] got;
        bit          have, bad, aborted;
        longint      t0;
        have    = (sbq.size() != 0);
        bad     = 0;
        aborted = 0;
        pat     = 11'h7FF;
        got     = 11'h7FF;
        t0      = cyc;
        e       = '0;
        if (have) begin
            e        = sbq.pop_front();
            pat[0]   = 1'b0;
            pat[8:1] = e.b;
            pat[9]   = (NB == 11) ? ^e.b : 1'b1;
        end
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (reset1 !== 1'b1) begin
                aborted = 1;
                break;
            end
            if (txd !== pat[i / CLKDIV]) bad = 1;
            if (i % CLKDIV == CLKDIV / 2) got[i / CLKDIV] = txd;
        end
        if (!aborted) begin
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL frame: unexpected frame data=%h, required no frame", got[8:1]);
            end else if (bad) begin
                errors++;
                $display("FAIL frame: got bits %b required %b", got[NB-1:0], pat[NB-1:0]);
            end
            if (have && e.contig) begin
                checks++;
                if (t0 != last_end + 1) begin
                    errors++;
                    $display("FAIL contig: start gap %0d cycles, required 0", t0 - last_end - 1);
                end
            end
            last_end = cyc;
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset1 === 1'b1 && txd === 1'b0) mon_frame();
        end
    end

    initial begin : stim
        int     n;
        int     ones;
        longint c0;

        // Reset and register map
        repeat (3) @(negedge clk);
        reset1 = 1'b1;
        #1 chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sel_addr0", sel, 0);
        addr = BASE + 32'd4;
        #1 chk("rst_status", rdata, 32'h1);
        chk("sel_status", sel, 1);
        addr = BASE;
        #1 chk("sel_data", sel, 1);
        chk("rdata_data", rdata, 32'h0);
        addr = 32'h800;
        #1 chk("sel_other", sel, 0);
        chk("rdata_other", rdata, 32'h0);
        addr = 32'd0;

        // Single byte: latency and frame length
        @(negedge clk);
        wr(8'hA5, 1, 0);
        chk("lat_edgeN_txd", txd, 1);
        chk("lat_edgeN_busy", busy, 1);
        @(negedge clk);
        chk("lat_edgeN1_txd", txd, 0);
        n = 0;
        while (busy && n < 10 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("frame_len_a5", n, FRAME);
        rd_status("status_after_a5", 32'h1);

        // Back-to-back
        @(negedge clk);
        wr(8'h00, 1, 0);
        wr(8'hFF, 1, 1);
        wait_idle("idle_b2b", 4 * FRAME);

        // Overflow: one popped, four fill, sixth dropped
        @(negedge clk);
        wr(8'h11, 1, 0);
        c0 = cyc;
        wr(8'h22, 1, 1);
        wr(8'h33, 1, 1);
        wr(8'h44, 1, 1);
        wr(8'h55, 1, 1);
        wr(8'h66, 0, 0);
        rd_status("ovf_status", 32'h6);
        rd_status("ovf_cleared", 32'h2);

        // Store on the STOP->START pop edge while full
        while (cyc < c0 + FRAME) @(negedge clk);
        wr(8'h77, 1, 1);
        rd_status("full_pushpop", 32'h2);
        wait_idle("idle_ovf", 8 * FRAME);

        // Mid-frame reset
        @(negedge clk);
        wr(8'h3C, 1, 0);
        repeat (10) @(negedge clk);
        #2 reset1 = 1'b0;
        #1 chk("midrst_txd", txd, 1);
        chk("midrst_busy", busy, 0);
        sbq.delete();
        repeat (3) @(negedge clk);
        reset1 = 1'b1;
        addr = BASE + 32'd4;
        #1 chk("midrst_status", rdata, 32'h1);
        addr = 32'd0;
        ones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd === 1'b1) ones++;
        end
        chk("midrst_no_residual", ones, 60);

        // Parity byte (odd popcount) and its frame length
        @(negedge clk);
        wr(8'h07, 1, 0);
        @(negedge clk);
        n = 0;
        while (busy && n < 10 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("frame_len_07", n, FRAME);
        wait_idle("idle_end", 2 * FRAME);
        chk("sbq_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped serial transmitter that sits downstream of the single-cycle ARM core's data bus, next to the 8-bit I/O ports. Byte stores to its data address are pushed into a small TX FIFO. The FIFO is drained onto a one-wire 8N1 asynchronous serial line (`txd`). A status word tells software when the FIFO is full or empty and whether a write was dropped. Top level decodes `sel` to mux `rdata` into ReadData, the same way the existing 0x800 port is handled.

## Interface
- `BASE`, 32'h804: byte address of the DATA register. STATUS is at `BASE+4`.
- `CLKDIV`, 16: clock cycles per serial bit. Legal range is ≥2.
- `DEPTH`, 4: TX FIFO entries. Must be a power of two, ≥2.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset1` in 1: asynchronous, active-low reset.
- `addr` in 32: data address (ALUResult/DataAdr).
- `wdata` in 32: store data. Only `[7:0]` is used.
- `we` in 1: store strobe (MemWrite).
- `re` in 1: load strobe (MemtoReg).
- `sel` out 1: combinational; 1 when `addr` equals `BASE` or `BASE+4`.
- `rdata` out 32: combinational read data.
- `txd` out 1: serial output; idle level is 1.
- `busy` out 1: 1 while a frame is being shifted, or while the FIFO is non-empty.

## Operation
- **DATA write.** `we` with `addr==BASE`.
  - FIFO not full: push `wdata[7:0]`.
  - FIFO full: byte is dropped and sticky `ovf` is set.
- **STATUS read.** `addr==BASE+4`: `rdata = {29'b0, ovf, full, empty}`.
  - `ovf` clears on the clock edge where `re` is 1 and `addr==BASE+4`.
  - If a dropped write occurs in the same cycle, the set wins.
- **DATA read.** `rdata = 0`. Any other address also gives `rdata = 0`.
- **FIFO.**
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy count is log2(DEPTH)+1 bits.
  - `full` = count==DEPTH; `empty` = count==0.
  - Push and pop on the same edge: both happen and count is unchanged. This holds when full, because the pop frees a slot, so the push is accepted and `ovf` is not set. When empty, no pop happens, so only the push takes effect.
- **FSM states: IDLE, START, DATA, STOP.**
  - IDLE: `txd=1`. If FIFO is non-empty, pop into an 8-bit shift register, clear the bit counter, go to START.
  - START: `txd=0` for CLKDIV cycles, then go to DATA.
  - DATA: `txd=shift[0]`, LSB first. Shift right every CLKDIV cycles. After the 8th bit, go to STOP.
  - STOP: `txd=1` for CLKDIV cycles. Then, if FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- **Counters.**
  - Baud counter counts 0..CLKDIV-1 and is cleared on every state entry.
  - Bit counter is 3 bits.
- `busy = (state!=IDLE) | ~empty`.

## Timing
- **Reset** (`reset1=0`, asynchronous):
  - state=IDLE, `txd=1`, FIFO empty, `ovf=0`, `busy=0`, counters 0.
  - `rdata` and `sel` are purely combinational.
- **Reset mid-frame.** Reset aborts the frame immediately: `txd` returns to 1 and FIFO contents are discarded.
- **Write to first start bit.** A write at edge N into an empty FIFO with the FSM in IDLE causes a pop at edge N+1. `txd` falls after edge N+1. Latency is 1 cycle.
- **Frame length.** One frame is 10·CLKDIV cycles: 1 start + 8 data + 1 stop.
- **Status updates.** A write at edge N is visible in STATUS (`empty=0`) from edge N onward. A same-cycle STATUS read returns the pre-edge value.

## Configuration
- **`UART_TX_PARITY_EN`**
  - Defined: FSM gains a PARITY state between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKDIV cycles, giving an 11·CLKDIV-cycle frame.
  - Undefined: no PARITY state; 8N1, 10·CLKDIV-cycle frame.
  - Register map and FIFO behaviour are identical in both builds.

## Test plan
- **Reset:** hold `reset1=0` for 3 cycles, then release → `txd=1`, STATUS=32'h1, `busy=0`, `sel=0` for `addr=0`.
- **Single byte:** CLKDIV=4; write 8'hA5 to 0x804 → `txd` low 1 cycle later, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop=1. Total 40 cycles, then `busy=0`.
- **Back-to-back:** write 8'h00 then 8'hFF on consecutive cycles → the two frames are contiguous, with no idle cycle between the first stop bit and the second start bit.
- **Overflow:** DEPTH=4; 6 writes while the first frame is shifting.
  - 1 write is popped, 4 fill the FIFO, and the 6th is dropped.
  - STATUS=32'h6 (ovf and full set).
  - A STATUS read clears ovf on that edge; the next read returns 32'h2.
- **Full push/pop:** write exactly on the STOP→START pop edge while full → write accepted, count stays 4, `ovf=0`.
- **Mid-frame reset:** assert `reset1` during the DATA state → `txd=1` asynchronously, STATUS=32'h1 after release, no residual frame transmitted.
- **Parity build** (`UART_TX_PARITY_EN` defined): write 8'h07 → parity bit 1, frame 11·CLKDIV cycles.
